pwm_dac_level_ctrl: RTL

- Sequences the 8-bit level that drives the PWM DAC and arbitrates it between two requesters: the host register path and the automatic level/ALC path.
- Slew-limits every level change into fixed steps on a step timer, so the analogue output never jumps.
- Sits between the control-register/ALC logic and the PWM DAC `PWM_source` input, in the `aclk` (122.88 MHz) domain.

---
 rtl/pwm_dac_level_ctrl_if.sv | 19 +
 rtl/pwm_dac_level_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pwm_dac_level_ctrl_if.sv
// Request/accept handshakes into the PWM DAC level controller.
// There are two requesters: the host register path and the ALC path.
interface pwm_dac_level_ctrl_if;
    logic [7:0] host_level;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] auto_level;
    logic       auto_valid;
    logic       auto_ready;

    modport master (
        output host_level, host_valid, auto_level, auto_valid,
        input  host_ready, auto_ready
    );
    modport slave (
        input  host_level, host_valid, auto_level, auto_valid,
        output host_ready, auto_ready
    );
endinterface

// File: rtl/pwm_dac_level_ctrl.sv
// Slew-limited, two-requester level sequencer feeding the PWM DAC PWM_source input.
// Optional soft mute: define PWM_LEVEL_SOFT_MUTE_EN to add the mute input.
module pwm_dac_level_ctrl #(
    parameter int unsigned STEP_DIV   = 256,
    parameter int unsigned STEP_SIZE  = 1,
    parameter logic [7:0]  INIT_LEVEL = 8'd0
) (
    input  logic                 aclk,
    input  logic                 reset,
    pwm_dac_level_ctrl_if.slave  req,
    input  logic                 auto_enable,
`ifdef PWM_LEVEL_SOFT_MUTE_EN
    input  logic                 mute,
`endif
    output logic [7:0]           level,
    output logic [7:0]           target,
    output logic                 ramp_busy,
    output logic                 owner
);
    typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

    localparam logic [15:0] TICK_AT = 16'(STEP_DIV - 1);
    localparam logic [7:0]  STEP8   = 8'(STEP_SIZE);
    localparam logic [8:0]  STEP9   = {1'b0, STEP8};

    state_t      state, state_d;
    logic [15:0] timer;
    logic        step_tick;
    logic [7:0]  host_shadow, auto_shadow, host_shadow_d, auto_shadow_d;
    logic [7:0]  level_d, target_d, tgt_sel, own_lvl;
    logic [8:0]  up_gap, dn_gap;
    logic        host_hs, auto_hs, own_hs, retarget, mute_now, mute_chg;
    logic        host_ready_d, auto_ready_d;

`ifdef PWM_LEVEL_SOFT_MUTE_EN
    logic mute_q;

    always_ff @(posedge aclk) begin
        if (reset) mute_q <= 1'b0;
        else       mute_q <= mute;
    end

    assign mute_now = mute;
    assign mute_chg = mute != mute_q;
`else
    assign mute_now = 1'b0;
    assign mute_chg = 1'b0;
`endif

    assign step_tick = (timer == TICK_AT);

    always_comb begin
        host_hs       = req.host_valid && req.host_ready;
        auto_hs       = req.auto_valid && req.auto_ready;
        host_shadow_d = host_hs ? req.host_level : host_shadow;
        auto_shadow_d = auto_hs ? req.auto_level : auto_shadow;
        own_hs        = owner ? auto_hs : host_hs;
        own_lvl       = owner ? req.auto_level : req.host_level;
        // A same-cycle write by the incoming owner is taken as its new target.
        tgt_sel       = auto_enable ? auto_shadow_d : host_shadow_d;
        if (mute_now) tgt_sel = 8'd0;
        retarget      = (auto_enable != owner) || mute_chg;
        up_gap        = {1'b0, target} - {1'b0, level};
        dn_gap        = {1'b0, level} - {1'b0, target};

        state_d  = state;
        level_d  = level;
        target_d = target;
        if (retarget) begin
            target_d = tgt_sel;
            if (tgt_sel != level)   state_d = RAMP;
            else if (state == RAMP) state_d = SETTLE;
        end else if (state == IDLE && own_hs) begin
            target_d = own_lvl;
            if (own_lvl != level) state_d = RAMP;
        end else if (step_tick) begin
            case (state)
                RAMP: begin
                    if (target > level) begin
                        if (up_gap <= STEP9) begin
                            level_d = target;
                            state_d = SETTLE;
                        end else begin
                            level_d = level + STEP8;
                        end
                    end else begin
                        if (dn_gap <= STEP9) begin
                            level_d = target;
                            state_d = SETTLE;
                        end else begin
                            level_d = level - STEP8;
                        end
                    end
                end
                SETTLE:  state_d = IDLE;
                default: state_d = state;
            endcase
        end

        // The owner side is open only when idle, unmuted and not just written.
        host_ready_d = auto_enable  || (state_d == IDLE && !own_hs && !mute_now);
        auto_ready_d = !auto_enable || (state_d == IDLE && !own_hs && !mute_now);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            level          <= INIT_LEVEL;
            target         <= INIT_LEVEL;
            host_shadow    <= INIT_LEVEL;
            auto_shadow    <= INIT_LEVEL;
            owner          <= 1'b0;
            ramp_busy      <= 1'b0;
            req.host_ready <= 1'b0;
            req.auto_ready <= 1'b0;
        end else begin
            state          <= state_d;
            timer          <= step_tick ? 16'd0 : timer + 16'd1;
            level          <= level_d;
            target         <= target_d;
            host_shadow    <= host_shadow_d;
            auto_shadow    <= auto_shadow_d;
            owner          <= auto_enable;
            ramp_busy      <= (state_d != IDLE);
            req.host_ready <= host_ready_d;
            req.auto_ready <= auto_ready_d;
        end
    end
endmodule
